// File: rtl/spam1_bus_defs.sv
// Shared bus definitions for the octal-register output-enable arbiter:
// FSM state encodings and default sizing constants.
package spam1_bus_defs;

  localparam int NREQ_DEF   = 4;
  localparam int SETTLE_DEF = 2;
  localparam int CNT_W      = 4;
  localparam int ST_W       = 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TURN    = 3'd1;
  localparam logic [2:0] S_DRIVE   = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  // Pointer width, kept at least 1 bit so a single-requester build still elaborates.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping to the lowest set bit when nothing above ptr is requesting.
module rr_pick
  import spam1_bus_defs::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PTR_W = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic             vld
);

  logic [NREQ-1:0] mask, hi, sel;

  for (genvar i = 0; i < NREQ; i++) begin : g_mask
    assign mask[i] = (PTR_W'(i) >= ptr);
  end

  assign hi  = req & mask;
  assign sel = (|hi) ? hi : req;
  // Isolate the lowest set bit of the selected half.
  assign win = sel & (~sel + NREQ'(1));
  assign vld = |req;

endmodule

// File: rtl/bus_oe_arbiter.sv
// Shared-bus arbiter for tri-state octal registers: grants one owner at a time,
// paces turnaround, settle and latch strobe, and drives all outputs from flops.
module bus_oe_arbiter
  import spam1_bus_defs::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int LOG    = 0
) (
  input  logic            CLK,
  input  logic            MR,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] _OE,
  output logic [NREQ-1:0] GNT,
  output logic            LOAD,
  output logic [NREQ-1:0] DONE,
  output logic            BUSY
);

  localparam int PTR_W = ptr_w(NREQ);

  if (SETTLE < 1 || SETTLE > 15 || NREQ < 1 || LOG < 0 || LOG > 1) begin : g_bad_param
    $error("bus_oe_arbiter: parameter out of range");
  end

  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr, own_idx, ptr_nx;
  logic [NREQ-1:0]  own, win;
  logic             vld, abort, own_req, drv;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req (REQ),
    .ptr (ptr),
    .win (win),
    .vld (vld)
  );

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (own[i]) own_idx = PTR_W'(i);
  end

  assign ptr_nx  = (own_idx == PTR_W'(NREQ - 1)) ? '0 : own_idx + 1'b1;
  assign own_req = |(REQ & own);
  assign drv     = (state == S_DRIVE) || (state == S_STROBE);

  always_ff @(posedge CLK) begin
    if (MR) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      own   <= '0;
      abort <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (vld) begin
            own   <= win;
            state <= S_TURN;
          end
        S_TURN: begin
          cnt   <= CNT_W'(SETTLE - 1);
          state <= S_DRIVE;
        end
        S_DRIVE:
          // An owner that gives up mid-settle is released without a strobe.
          if (!own_req) begin
            abort <= 1'b1;
            state <= S_RELEASE;
          end else if (cnt == '0) begin
            state <= S_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        S_STROBE: begin
          ptr   <= ptr_nx;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          abort <= 1'b0;
          if (vld) begin
            own   <= win;
            state <= S_TURN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are a registered decode of the current state, so they trail it by one cycle.
  always_ff @(posedge CLK) begin
    if (MR) begin
      _OE  <= '1;
      GNT  <= '0;
      LOAD <= 1'b0;
      DONE <= '0;
      BUSY <= 1'b0;
    end else begin
      _OE  <= drv ? ~own : '1;
      GNT  <= drv ? own : '0;
      LOAD <= (state == S_STROBE);
      DONE <= (state == S_RELEASE && !abort) ? own : '0;
      BUSY <= (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bus_oe_arbiter.sv
// Scoreboard bench for bus_oe_arbiter (NREQ=4, SETTLE=2): directed transfers
// with expected grants/completions queued, plus a per-cycle bus-safety monitor.
module tb_bus_oe_arbiter;

  localparam int NREQ   = 4;
  localparam int SETTLE = 2;
  localparam int LOG    = 0;

  logic            CLK = 1'b0;
  logic            MR  = 1'b1;
  logic [NREQ-1:0] REQ = '0;
  logic [NREQ-1:0] oe_n, gnt, done;
  logic            load, busy;

  bus_oe_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE), .LOG(LOG)) dut (
    .CLK  (CLK),
    .MR   (MR),
    .REQ  (REQ),
    ._OE  (oe_n),
    .GNT  (gnt),
    .LOAD (load),
    .DONE (done),
    .BUSY (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  logic mr_q = 1'b1;
  always @(posedge CLK) begin
    cyc  <= cyc + 1;
    mr_q <= MR;
  end

  typedef struct {
    logic [NREQ-1:0] vec;
    int              cyc;
  } exp_t;

  exp_t gnt_q[$];
  exp_t done_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_g(input logic [NREQ-1:0] v, input int c);
    gnt_q.push_back('{vec: v, cyc: c});
  endfunction

  function automatic void push_d(input logic [NREQ-1:0] v, input int c);
    done_q.push_back('{vec: v, cyc: c});
  endfunction

  // Monitor: safety invariants every cycle, scoreboard pops on new grants and completions.
  logic [NREQ-1:0] prev_low = '0, prev_gnt = '0, last_load_own = '0;
  int              loads_since = 0;
  always @(negedge CLK) begin
    logic [NREQ-1:0] low;
    exp_t            e;
    low = ~oe_n;
    if (mr_q) loads_since = 0;
    chk("oe_at_most_one_low", ($countones(low) <= 1), 1);
    if (load) begin
      chk("load_with_one_oe", $countones(low), 1);
      loads_since++;
      last_load_own = gnt;
    end
    if (low != 0 && prev_low != 0) chk("owner_gap", low, prev_low);
    if (done != 0) begin
      chk("one_load_before_done", loads_since, 1);
      chk("done_matches_loaded_owner", done, last_load_own);
      loads_since = 0;
    end
    if (sb_en && gnt != 0 && prev_gnt == 0) begin
      if (gnt_q.size() == 0) chk("grant_unexpected", gnt, 0);
      else begin
        e = gnt_q.pop_front();
        chk("grant", gnt, e.vec);
        if (e.cyc >= 0) chk("grant_cycle", cyc, e.cyc);
      end
    end
    if (sb_en && done != 0) begin
      if (done_q.size() == 0) chk("done_unexpected", done, 0);
      else begin
        e = done_q.pop_front();
        chk("done", done, e.vec);
        if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
      end
    end
    prev_low = low;
    prev_gnt = gnt;
  end

  if (LOG != 0) begin : g_log
    always @(negedge CLK)
      if (gnt != prev_gnt) $display("[%0t] owner %b busy %b", $time, gnt, busy);
  end

  task automatic reset_dut();
    MR  = 1'b1;
    REQ = '0;
    repeat (2) @(negedge CLK);
    MR = 1'b0;
  endtask

  // Run until n strobes; hold=1 keeps REQ until the last one, else each owner drops at its strobe.
  task automatic serve(input int n, input bit hold, input int maxc);
    int got = 0;
    int c   = 0;
    while (got < n && c < maxc) begin
      @(negedge CLK);
      c++;
      if (load) begin
        got++;
        if (hold) begin
          if (got == n) REQ = '0;
        end else begin
          REQ = REQ & ~gnt;
        end
      end
    end
    chk("serve_strobes", got, n);
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((gnt_q.size() != 0 || done_q.size() != 0 || busy) && c < maxc) begin
      @(negedge CLK);
      c++;
    end
    chk("drain_grants", gnt_q.size(), 0);
    chk("drain_dones", done_q.size(), 0);
    chk("drain_idle", busy, 0);
    gnt_q.delete();
    done_q.delete();
  endtask

  initial begin
    int k;
    int w;
    logic [1:0] b;

    repeat (3) @(negedge CLK);
    chk("rst_oe", oe_n, 4'b1111);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_load", load, 0);
    chk("rst_done", done, 4'b0000);
    chk("rst_busy", busy, 0);
    MR = 1'b0;
    @(negedge CLK);

    // Single transfer latency: edge k samples REQ.
    REQ = 4'b0001;
    k = cyc + 1;
    push_g(4'b0001, k + 2);
    push_d(4'b0001, k + 5);
    for (int c = k; c <= k + 6; c++) begin
      @(negedge CLK);
      chk("t1_oe", oe_n, (c >= k + 2 && c <= k + 4) ? 4'b1110 : 4'b1111);
      chk("t1_load", load, (c == k + 4));
      chk("t1_busy", busy, (c >= k + 1 && c <= k + 5));
      if (load) REQ = '0;
    end
    drain(50);

    // All requesting from a fresh pointer: 0,1,2,3,0.
    reset_dut();
    REQ = 4'b1111;
    push_g(4'b0001, -1); push_g(4'b0010, -1); push_g(4'b0100, -1);
    push_g(4'b1000, -1); push_g(4'b0001, -1);
    push_d(4'b0001, -1); push_d(4'b0010, -1); push_d(4'b0100, -1);
    push_d(4'b1000, -1); push_d(4'b0001, -1);
    serve(5, 1'b1, 200);
    drain(50);

    // Abandon during the first drive cycle: no strobe, no completion.
    REQ = 4'b0100;
    k = cyc + 1;
    push_g(4'b0100, k + 2);
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (oe_n[2] && w < 10);
    chk("t3_drive_cycle", cyc, k + 2);
    REQ = '0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge CLK);
      chk("t3_no_load", load, 0);
      chk("t3_no_done", done, 4'b0000);
      if (j == 2) chk("t3_released", oe_n, 4'b1111);
    end
    drain(20);
    REQ = 4'b0100;
    push_g(4'b0100, -1);
    push_d(4'b0100, -1);
    serve(1, 1'b0, 50);
    drain(50);

    // Master reset while the strobe is visible aborts the transfer.
    REQ = 4'b0001;
    push_g(4'b0001, -1);
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (!load && w < 20);
    chk("t4_strobe_seen", load, 1);
    MR  = 1'b1;
    REQ = '0;
    @(negedge CLK);
    chk("t4_oe", oe_n, 4'b1111);
    chk("t4_load", load, 0);
    chk("t4_busy", busy, 0);
    chk("t4_gnt", gnt, 4'b0000);
    chk("t4_done", done, 4'b0000);
    MR = 1'b0;
    // Pointer back at 0 means index 0 wins over index 3.
    REQ = 4'b1001;
    push_g(4'b0001, -1); push_g(4'b1000, -1);
    push_d(4'b0001, -1); push_d(4'b1000, -1);
    serve(2, 1'b0, 100);
    drain(50);

    // Random request traffic under the safety monitor only.
    sb_en = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 7) == 0) begin
        b   = 2'($urandom_range(0, 3));
        REQ = REQ ^ (4'b0001 << b);
      end
      if (load && $urandom_range(0, 1) == 1) REQ = REQ & ~gnt;
    end
    REQ = '0;
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_oe_arbiter.md
BUS_OE_ARBITER -- requirements
Module: bus_oe_arbiter

Interface
REQ-001: Parameter NREQ, default 4: number of requesters, each owning one tri-state octal register on the shared data bus.
REQ-002: Parameter SETTLE, default 2, range 1..15: DRIVE cycles allowed for bus data to settle before the latch strobe.
REQ-003: Parameter LOG, default 0: when 1, print a timestamped line on every state transition and every grant.
REQ-004: CLK  input  1  system clock; all state changes on posedge CLK.
REQ-005: MR  input  1  master reset; synchronous, active-high.
REQ-006: REQ  input  NREQ  per-requester bus request, level, held high until DONE or abandonment.
REQ-007: _OE  output  NREQ  active-low output enables, one per requester register.
REQ-008: GNT  output  NREQ  active-high one-hot copy of the current owner; all zero when nobody drives the bus.
REQ-009: LOAD  output  1  one-cycle active-high strobe, used as the clock for the destination register.
REQ-010: DONE  output  NREQ  one-cycle one-hot pulse confirming a completed transfer.
REQ-011: BUSY  output  1  high in any state other than IDLE.

Function
REQ-012: All outputs are driven from flops, with no combinational path from REQ to any output.
REQ-013: The FSM states are IDLE, TURN, DRIVE, STROBE and RELEASE.
REQ-014: IDLE: all _OE high; when any REQ bit is 1 at the edge, latch the round-robin winner and enter TURN.
REQ-015: TURN lasts 1 cycle with all _OE high, as a bus-turnaround dead cycle.
REQ-016: DRIVE: _OE[w]=0 and GNT[w]=1; the state lasts exactly SETTLE cycles, counted by a 4-bit down-counter.
REQ-017: STROBE lasts 1 cycle with _OE[w]=0 and LOAD=1.
REQ-018: RELEASE lasts 1 cycle with all _OE high and DONE[w]=1; then go to TURN with a new winner if any REQ is 1, else IDLE.
REQ-019: Latency when REQ is first sampled at edge k from IDLE: _OE[w] is low from edge k+2; LOAD is high in cycle k+2+SETTLE; DONE is high in cycle k+3+SETTLE.
REQ-020: Round-robin: the search starts at the index after the last completed owner and wraps from NREQ-1 to 0; after reset, index 0 has the highest priority.
REQ-021: If REQ[w] falls during DRIVE, go to RELEASE next cycle with no LOAD and no DONE, and do not advance the pointer.
REQ-022: REQ[w] falling during STROBE has no effect; the transfer completes.
REQ-023: REQ changes on non-owner bits during a transaction are ignored until the next arbitration.
REQ-024: Invariant: at most one _OE bit is low in any cycle.
REQ-025: Invariant: between two different owners there is at least one cycle with all _OE high.
REQ-026: Invariant: LOAD is only high while exactly one _OE is low.
REQ-027: A REQ bit held continuously is re-granted only after every other requesting bit has been served once.

Reset
REQ-028: MR=1 at an edge forces: state IDLE, _OE all 1, GNT 0, LOAD 0, DONE 0, BUSY 0, pointer 0, counter 0.
REQ-029: MR asserted mid-transaction aborts the transaction at that edge with no LOAD and no DONE.
REQ-030: MR has priority over every other input.

Structure
REQ-031: A shared include spam1_bus_defs holds the state encodings (3-bit binary) and the NREQ and SETTLE width constants.
REQ-032: One sub-module, rr_pick, provides a combinational round-robin picker: inputs req[NREQ] and ptr, outputs a one-hot winner and a valid flag.
REQ-033: The FSM, counter and output flops stay in bus_oe_arbiter.

Verification (NREQ=4, SETTLE=2)
REQ-034: Reset, then REQ=0001 at edge 0 -> _OE=1110 in cycles 2-4, LOAD=1 in cycle 4, DONE=0001 in cycle 5, then IDLE in cycle 6.
REQ-035: REQ=1111 held -> grant order 0,1,2,3,0.
REQ-036: REQ=1111 held -> between owners, every cycle shows at most one _OE low and at least one all-high cycle.
REQ-037: REQ=0100 granted, REQ[2] dropped in the first DRIVE cycle -> RELEASE with LOAD=0 and DONE=0000; the next REQ=0100 is granted again.
REQ-038: MR=1 pulsed during STROBE -> the next cycle shows _OE=1111, LOAD=0, BUSY=0; REQ=1000 afterwards is granted as index 3 with the pointer restarted at 0.
REQ-039: Random REQ for 10,000 cycles with a checker -> zero violations of REQ-024 to REQ-026; every DONE is preceded by exactly one LOAD.
